// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared definitions for the key conditioner: the per-channel FSM state
// encoding, counter widths and the default parameter values used by the top.
// No ports (package).
// -----------------------------------------------------------------------------
package key_cond_pkg;

    // Debounce counter covers DB_CYCLES up to 65535.
    localparam int DB_CNT_W  = 16;
    // Repeat counter covers REP_DELAY / REP_PERIOD up to 2^26-1.
    localparam int REP_CNT_W = 26;

    localparam int DEF_NKEYS         = 4;
    localparam int DEF_DB_CYCLES     = 50000;
    localparam int DEF_REP_DELAY     = 25000000;
    localparam int DEF_REP_PERIOD    = 5000000;
    localparam bit DEF_IN_ACTIVE_LOW = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_WAIT   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-flop synchroniser, debounce FSM, registered level output
// with press/release edge pulses, and an auto-repeat pulse generator.
// Ports:
//   clk           - sole clock
//   reset         - synchronous active-high reset
//   btn           - raw button level, already polarity corrected
//   keys          - debounced level, 1 while the key is accepted as held
//   press         - one-cycle pulse in the first cycle keys is 1
//   release_pulse - one-cycle pulse in the first cycle keys is 0
//                   (named release_pulse because release is a reserved word)
//   rpt           - one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic keys,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam logic [DB_CNT_W-1:0]  DB_LAST      = DB_CNT_W'(DB_CYCLES - 1);
    localparam logic [DB_CNT_W-1:0]  DB_ONE       = DB_CNT_W'(1);
    localparam logic [DB_CNT_W-1:0]  DB_MAX       = '1;
    localparam logic [REP_CNT_W-1:0] REP_DELAY_C  = REP_CNT_W'(REP_DELAY);
    localparam logic [REP_CNT_W-1:0] REP_PERIOD_C = REP_CNT_W'(REP_PERIOD);
    localparam logic [REP_CNT_W-1:0] REP_ONE      = REP_CNT_W'(1);
    localparam logic [REP_CNT_W-1:0] REP_MAX      = '1;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    key_state_e           state_q, state_d;
    logic [DB_CNT_W-1:0]  db_cnt_q, db_cnt_d;
    logic [REP_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                 rep_first_q, rep_first_d;
    logic                 keys_q, keys_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic                 rpt_q, rpt_d;
    logic [REP_CNT_W-1:0] rep_thr;

    // The first repeat waits REP_DELAY held cycles, later ones REP_PERIOD.
    assign rep_thr = rep_first_q ? REP_DELAY_C : REP_PERIOD_C;

    // Next-state logic: synchroniser shift, debounce FSM and repeat counter.
    // The repeat counter restarts at 1 on each pulse so it never needs to
    // count past the larger threshold; it only advances in HELD, so a release
    // bounce freezes the schedule rather than restarting it.
    always_comb begin
        sync1_d     = btn;
        sync2_d     = sync1_q;
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rpt_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    db_cnt_d    = '0;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else if (db_cnt_q != DB_MAX) begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            ST_HELD: begin
                if (rep_cnt_q == rep_thr) begin
                    rpt_d       = 1'b1;
                    rep_cnt_d   = REP_ONE;
                    rep_first_d = 1'b0;
                end else if (rep_cnt_q != REP_MAX) begin
                    rep_cnt_d = rep_cnt_q + REP_ONE;
                end
                if (!sync2_q) begin
                    state_d  = ST_REL_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            ST_REL_WAIT: begin
                if (sync2_q) begin
                    state_d  = ST_HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q != DB_MAX) begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered one cycle behind the FSM state so that a clean
    // step reaches keys DB_CYCLES+2 edges after it is first sampled; press and
    // release are the edges of that registered level.
    always_comb begin
        keys_d    = (state_q == ST_HELD) || (state_q == ST_REL_WAIT);
        press_d   = keys_d & ~keys_q;
        release_d = ~keys_d & keys_q;
    end

    // State register. Clearing keys_q on reset is what suppresses a release
    // pulse when reset interrupts a held key.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            keys_q      <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            rpt_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            keys_q      <= keys_d;
            press_q     <= press_d;
            release_q   <= release_d;
            rpt_q       <= rpt_d;
        end
    end

    assign keys          = keys_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign rpt           = rpt_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Conditions NKEYS raw push-buttons into clean active-high key levels plus
// press, release and auto-repeat pulses. Channels are fully independent.
// Ports:
//   clk           - sole clock
//   reset         - synchronous active-high reset
//   btn_in        - raw asynchronous button levels [NKEYS]
//   keys          - debounced levels (bit0 left, bit1 right) [NKEYS]
//   press         - one-cycle pulse on accepted press [NKEYS]
//   release_pulse - one-cycle pulse on accepted release [NKEYS]
//   rpt           - one-cycle auto-repeat pulse while held [NKEYS]
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NKEYS         = DEF_NKEYS,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REP_DELAY     = DEF_REP_DELAY,
    parameter int REP_PERIOD    = DEF_REP_PERIOD,
    parameter bit IN_ACTIVE_LOW = DEF_IN_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] btn_in,
    output logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] press,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] rpt
);

    logic [NKEYS-1:0] btn_pol;

    // Inversion happens before the synchroniser so every channel sees a
    // pressed-is-1 level.
    assign btn_pol = IN_ACTIVE_LOW ? ~btn_in : btn_in;

    for (genvar i = 0; i < NKEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn_pol[i]),
            .keys          (keys[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .rpt           (rpt[i])
        );
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter NKEYS, default 4, number of key channels.
REQ-002 SHALL have parameter DB_CYCLES, default 50000, consecutive stable cycles needed to accept a level change (legal range 2..65535).
REQ-003 SHALL have parameter REP_DELAY, default 25000000, held cycles before the first auto-repeat pulse (legal range 1..2^26-1).
REQ-004 SHALL have parameter REP_PERIOD, default 5000000, cycles between later auto-repeat pulses (legal range 1..2^26-1).
REQ-005 SHALL have parameter IN_ACTIVE_LOW, default 0; when 1, raw inputs are inverted before synchronisation.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port btn_in, input, NKEYS, raw asynchronous button levels.
REQ-009 SHALL have port keys, output, NKEYS, debounced active-high levels driving the game keys input (bit0 left, bit1 right).
REQ-010 SHALL have port press, output, NKEYS, one-cycle pulse on accepted press.
REQ-011 SHALL have port release, output, NKEYS, one-cycle pulse on accepted release.
REQ-012 SHALL have port rpt, output, NKEYS, one-cycle auto-repeat pulse while held.

Function
REQ-013 SHALL pass each (optionally inverted) input through a 2-flop synchroniser; all later logic uses only the second flop.
REQ-014 SHALL run a per-channel FSM: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-015 IDLE -> PRESS_WAIT when sync=1; counter loaded to 1.
REQ-016 PRESS_WAIT: sync=0 -> IDLE, counter cleared; sync=1 with counter=DB_CYCLES-1 -> HELD; else counter increments.
REQ-017 HELD -> REL_WAIT when sync=0; REL_WAIT mirrors PRESS_WAIT with inverted level, returning to HELD on bounce and to IDLE on acceptance.
REQ-018 keys[i] SHALL be 1 exactly while state is HELD or REL_WAIT.
REQ-019 A clean input step SHALL change keys exactly DB_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-020 press[i] SHALL pulse in the first cycle keys[i] is 1; release[i] in the first cycle keys[i] is 0; never both in one cycle.
REQ-021 Repeat counter SHALL clear on entry to HELD, increment in HELD, and hold its value in REL_WAIT; rpt[i] pulses when count reaches REP_DELAY, then every REP_PERIOD cycles, and never pulses in the same cycle as press[i].
REQ-022 A bounce returning REL_WAIT -> HELD SHALL neither pulse press nor restart the repeat schedule.
REQ-023 Counters SHALL saturate, never wrap; channels SHALL be fully independent, simultaneous events on several channels all honoured in the same cycle.

Reset
REQ-024 Reset SHALL clear synchronisers, counters, and set all FSMs to IDLE; keys, press, release, rpt SHALL read 0 on the first edge after reset is sampled high.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort without any release pulse; a button held across reset deassertion SHALL be re-debounced from IDLE.

Structure
REQ-026 Package key_cond_pkg SHALL hold the FSM state enum, counter width constants (16-bit debounce, 26-bit repeat), and default parameter values.
REQ-027 Per-channel logic SHALL live in sub-module key_debounce_ch, instantiated NKEYS times by generate; the top holds only inversion and port assembly.

Verification (DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3)
REQ-028 Clean press of btn_in[0] at edge 0 -> keys[0]=1 and press[0] pulse at edge 6; other bits stay 0.
REQ-029 btn_in[1] toggling 1,0,1 with each level held 2 cycles, then held high -> no output until the final high is stable for 4 cycles; exactly one press[1].
REQ-030 Hold key 0 for 30 cycles after acceptance -> rpt[0] at hold counts 10, 13, 16, 19, 22, 25, 28; release after 4 stable lows with exactly one release[0].
REQ-031 Release glitch of 2 low cycles during hold -> keys stays 1, no release/press, repeat cadence unshifted.
REQ-032 Reset pulsed while keys=4'b0011 -> all outputs 0 next edge, no release pulses; buttons still held -> keys returns after 6 edges.
REQ-033 IN_ACTIVE_LOW=1, btn_in=4'b1111 idle, drive 4'b1100 -> keys=4'b0011 after 6 edges, press on bits 0 and 1 in the same cycle.
